// File: rtl/logic_sweep_unit_pkg.sv
// Shared definitions for the logic sweep unit: function-mode encodings,
// FSM state encoding and the legal range of the function input width.
package logic_pkg;

    // Boolean function applied to every swept input vector.
    typedef enum logic [1:0] {
        LSU_OR   = 2'b00,  // OR-reduce
        LSU_ANDN = 2'b01,  // x == 1 (only bit0 set)
        LSU_XOR  = 2'b10,  // XOR-reduce (odd parity)
        LSU_NOR  = 2'b11   // NOR-reduce (x == 0)
    } lsu_mode_e;

    // Sweep controller states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SWEEP = 2'b01,
        ST_DONE  = 2'b10
    } lsu_state_e;

    localparam int LSU_N_IN_MIN = 2;
    localparam int LSU_N_IN_MAX = 8;

    // True when the function input width is one the unit supports.
    function automatic bit lsu_n_in_legal(input int n);
        return (n >= LSU_N_IN_MIN) && (n <= LSU_N_IN_MAX);
    endfunction

endpackage

// File: rtl/logic_sweep_unit_func_eval.sv
// lsu_func_eval: purely combinational evaluation of the selected Boolean
// function on an N_IN-bit vector. The reduction chains are built from gate
// primitives, one gate per input bit, then a mode mux picks the result.
module lsu_func_eval
    import logic_pkg::*;
#(
    parameter int N_IN = 3
)
(
    input  logic [1:0]      mode,
    input  logic [N_IN-1:0] x,
    output logic            s
);

    // Running reductions: element i covers x[i:0].
    wire [N_IN-1:0] or_c;
    wire [N_IN-1:0] xor_c;
    wire [N_IN-1:0] andn_c;
    wire            nor_s;

    buf u_or_0   (or_c[0],   x[0]);
    buf u_xor_0  (xor_c[0],  x[0]);
    buf u_andn_0 (andn_c[0], x[0]);

    genvar i;
    for (i = 1; i < N_IN; i++) begin : g_chain
        wire x_n;
        not u_not  (x_n,       x[i]);
        or  u_or   (or_c[i],   or_c[i-1],   x[i]);
        xor u_xor  (xor_c[i],  xor_c[i-1],  x[i]);
        and u_andn (andn_c[i], andn_c[i-1], x_n);
    end

    not u_nor (nor_s, or_c[N_IN-1]);

    // Select the requested function's result.
    always_comb begin
        s = 1'b0;
        case (lsu_mode_e'(mode))
            LSU_OR:   s = or_c[N_IN-1];
            LSU_ANDN: s = andn_c[N_IN-1];
            LSU_XOR:  s = xor_c[N_IN-1];
            LSU_NOR:  s = nor_s;
            default:  s = 1'b0;
        endcase
    end

endmodule

// File: rtl/logic_sweep_unit.sv
// logic_sweep_unit: on an accepted start, steps an index through all 2^N_IN
// input vectors (one per clock), streams f(vec) out and accumulates the
// truth table and its ones count. Optional macro LSU_STALL_EN adds a stall_i
// port that pauses the sweep; without it the sweep never pauses.
module logic_sweep_unit
    import logic_pkg::*;
#(
    parameter  int N_IN = 3,
    localparam int TT_W = 2 ** N_IN
)
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic [1:0]      mode_i,
`ifdef LSU_STALL_EN
    input  logic            stall_i,
`endif
    output logic [N_IN-1:0] vec_o,
    output logic            s_o,
    output logic            valid_o,
    output logic            busy_o,
    output logic            done_o,
    output logic [TT_W-1:0] tt_o,
    output logic [N_IN:0]   ones_o
);

    if (!lsu_n_in_legal(N_IN)) begin : g_bad_n_in
        $error("logic_sweep_unit: N_IN=%0d is outside the supported range 2..8", N_IN);
    end

    localparam logic [N_IN-1:0] IDX_LAST = N_IN'(TT_W - 1);

    lsu_state_e      state_q;
    lsu_state_e      state_d;
    logic [N_IN-1:0] idx_q;
    logic [1:0]      mode_q;
    logic [TT_W-1:0] tt_q;
    logic [N_IN:0]   ones_q;
    logic            s_raw;
    logic            stall;
    logic            sweep;
    logic            advance;
    logic            accept;

`ifdef LSU_STALL_EN
    assign stall = stall_i;
`else
    assign stall = 1'b0;
`endif

    assign sweep   = (state_q == ST_SWEEP);
    assign advance = sweep && !stall;
    assign accept  = (state_q == ST_IDLE) && start_i;

    lsu_func_eval #(.N_IN(N_IN)) u_eval (
        .mode (mode_q),
        .x    (idx_q),
        .s    (s_raw)
    );

    // Next-state logic; starts outside IDLE are dropped, not queued.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start_i) state_d = ST_SWEEP;
            ST_SWEEP: if (advance && (idx_q == IDX_LAST)) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State register, index counter and truth-table/ones accumulators.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            tt_q    <= '0;
            ones_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                idx_q  <= '0;
                tt_q   <= '0;
                ones_q <= '0;
            end else if (advance) begin
                tt_q[idx_q] <= s_raw;
                ones_q      <= ones_q + {{N_IN{1'b0}}, s_raw};
                idx_q       <= idx_q + 1'b1;
            end
        end
    end

    // Function select is captured once per sweep; later mode_i changes are ignored.
    always_ff @(posedge clk) begin
        if (accept) mode_q <= mode_i;
    end

    // Stream outputs are forced low outside SWEEP so IDLE and DONE read as zero.
    always_comb begin
        vec_o   = sweep ? idx_q : '0;
        s_o     = sweep & s_raw;
        valid_o = advance;
        busy_o  = (state_q != ST_IDLE);
        done_o  = (state_q == ST_DONE);
        tt_o    = tt_q;
        ones_o  = ones_q;
    end

endmodule

// File: tb/tb_logic_sweep_unit.sv
// Scoreboard bench for logic_sweep_unit with N_IN=3 and N_IN=8 instances.
// Expected samples and final truth tables come from a plain arithmetic model.
module tb_logic_sweep_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic       start3, stall3;
    logic [1:0] mode3;
    logic [2:0] vec3;
    logic       s3, valid3, busy3, done3;
    logic [7:0] tt3;
    logic [3:0] ones3;

    logic         start8;
    logic [1:0]   mode8;
    logic [7:0]   vec8;
    logic         s8, valid8, busy8, done8;
    logic [255:0] tt8;
    logic [8:0]   ones8;

    int n_tests = 0;
    int n_fail  = 0;

    logic [2:0]   q_vec3[$];
    logic         q_s3[$];
    logic [7:0]   q_tt3[$];
    logic [3:0]   q_ones3[$];
    logic [7:0]   q_vec8[$];
    logic         q_s8[$];
    logic [255:0] q_tt8[$];
    logic [8:0]   q_ones8[$];

    logic prev_done3 = 1'b0;
    logic prev_done8 = 1'b0;

    logic_sweep_unit #(.N_IN(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start_i(start3), .mode_i(mode3),
`ifdef LSU_STALL_EN
        .stall_i(stall3),
`endif
        .vec_o(vec3), .s_o(s3), .valid_o(valid3), .busy_o(busy3),
        .done_o(done3), .tt_o(tt3), .ones_o(ones3)
    );

    logic_sweep_unit #(.N_IN(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start_i(start8), .mode_i(mode8),
`ifdef LSU_STALL_EN
        .stall_i(1'b0),
`endif
        .vec_o(vec8), .s_o(s8), .valid_o(valid8), .busy_o(busy8),
        .done_o(done8), .tt_o(tt8), .ones_o(ones8)
    );

    // Reference function from the mode definitions.
    function automatic logic f_ref(input logic [1:0] m, input int x);
        case (m)
            2'b00:   return x != 0;
            2'b01:   return x == 1;
            2'b10:   return ($countones(x) % 2) == 1;
            default: return x == 0;
        endcase
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: event missing or unexpected", name);
    endtask

    // Monitor for the 3-input instance.
    always @(negedge clk) begin
        if (valid3) begin
            if (q_vec3.size() == 0) fail_now("unexpected_valid3");
            else begin
                check("vec3", vec3, q_vec3.pop_front());
                check("s3", s3, q_s3.pop_front());
            end
        end
        if (done3) begin
            if (q_tt3.size() == 0) fail_now("unexpected_done3");
            else begin
                check("tt3", tt3, q_tt3.pop_front());
                check("ones3", ones3, q_ones3.pop_front());
                check("samples_left3", q_vec3.size(), 0);
            end
            check("done3_single", prev_done3, 0);
            check("done3_no_valid", valid3, 0);
        end
        prev_done3 = done3;
    end

    // Monitor for the 8-input instance.
    always @(negedge clk) begin
        if (valid8) begin
            if (q_vec8.size() == 0) fail_now("unexpected_valid8");
            else begin
                check("vec8", vec8, q_vec8.pop_front());
                check("s8", s8, q_s8.pop_front());
            end
        end
        if (done8) begin
            if (q_tt8.size() == 0) fail_now("unexpected_done8");
            else begin
                check("tt8", tt8, q_tt8.pop_front());
                check("ones8", ones8, q_ones8.pop_front());
                check("samples_left8", q_vec8.size(), 0);
            end
            check("done8_single", prev_done8, 0);
        end
        prev_done8 = done8;
    end

    task automatic push_exp3(input logic [1:0] m, output logic [7:0] tt, output int ones);
        tt = '0;
        ones = 0;
        for (int k = 0; k < 8; k++) begin
            logic s;
            s = f_ref(m, k);
            q_vec3.push_back(3'(k));
            q_s3.push_back(s);
            tt[k] = s;
            ones += int'(s);
        end
        q_tt3.push_back(tt);
        q_ones3.push_back(4'(ones));
    endtask

    task automatic stall_inject();
`ifdef LSU_STALL_EN
        int w = 0;
        while (!(valid3 && vec3 == 3'd1) && w < 20) begin
            @(negedge clk); #1;
            w++;
        end
        @(posedge clk); #1;
        stall3 = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("stall_vec3", vec3, 2);
            check("stall_valid3", valid3, 0);
        end
        @(posedge clk); #1;
        stall3 = 1'b0;
`endif
    endtask

    task automatic run3(input logic [1:0] m, input bit hold_start, input bit do_stall);
        logic [7:0] tt;
        int ones, cyc, exp_cyc;
        bit seen;
        push_exp3(m, tt, ones);
        exp_cyc = do_stall ? 12 : 9;
        @(negedge clk);
        mode3 = m;
        start3 = 1'b1;
        @(posedge clk); #1;
        if (!hold_start) start3 = 1'b0;
        mode3 = ~m;
        cyc = 0;
        seen = 0;
        fork
            begin
                while (!seen && cyc < 40) begin
                    @(negedge clk);
                    cyc++;
                    if (done3) seen = 1;
                end
            end
            begin
                if (do_stall) stall_inject();
            end
        join
        if (!seen) fail_now("done3_timeout");
        else check("done3_cycle", cyc, exp_cyc);
        // start3 stays high through the DONE-exit edge when held, then drops in IDLE.
        @(negedge clk);
        start3 = 1'b0;
        repeat (3) @(negedge clk);
        check("busy_idle3", busy3, 0);
        check("tt_held3", tt3, tt);
        check("ones_held3", ones3, ones);
    endtask

    task automatic reset_mid3(input logic [1:0] m);
        logic [7:0] tt;
        int ones, w;
        push_exp3(m, tt, ones);
        @(negedge clk);
        mode3 = m;
        start3 = 1'b1;
        @(posedge clk); #1;
        start3 = 1'b0;
        w = 0;
        while (!(valid3 && vec3 == 3'd5) && w < 20) begin
            @(negedge clk); #1;
            w++;
        end
        if (w >= 20) fail_now("reach_idx5");
        rst_n = 1'b0;
        q_vec3.delete();
        q_s3.delete();
        q_tt3.delete();
        q_ones3.delete();
        @(negedge clk);
        check("midrst_outs3", {vec3, s3, valid3, busy3, done3, tt3, ones3}, 0);
        rst_n = 1'b1;
    endtask

    task automatic run8(input logic [1:0] m);
        logic [255:0] tt;
        int ones, cyc;
        bit seen;
        tt = '0;
        ones = 0;
        for (int k = 0; k < 256; k++) begin
            logic s;
            s = f_ref(m, k);
            q_vec8.push_back(8'(k));
            q_s8.push_back(s);
            tt[k] = s;
            ones += int'(s);
        end
        q_tt8.push_back(tt);
        q_ones8.push_back(9'(ones));
        @(negedge clk);
        mode8 = m;
        start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        cyc = 0;
        seen = 0;
        while (!seen && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (cyc % 37 == 0) mode8 = 2'($urandom_range(0, 3));
            if (done8) seen = 1;
        end
        if (!seen) fail_now("done8_timeout");
        else check("done8_cycle", cyc, 257);
        @(negedge clk);
        check("busy_idle8", busy8, 0);
        check("tt_held8", tt8, tt);
        check("ones_held8", ones8, ones);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        start3 = 1'b0; mode3 = 2'b00; stall3 = 1'b0;
        start8 = 1'b0; mode8 = 2'b00;
        repeat (3) @(negedge clk);
        check("reset3", {vec3, s3, valid3, busy3, done3, tt3, ones3}, 0);
        check("reset8", {vec8, s8, valid8, busy8, done8, ones8}, 0);
        check("reset_tt8", tt8, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run3(2'b00, 0, 0);
        run3(2'b01, 0, 0);
        run3(2'b10, 0, 0);
        run3(2'b11, 0, 0);
        run3(2'b10, 1, 0);
        reset_mid3(2'b00);
        run3(2'b01, 0, 0);
`ifdef LSU_STALL_EN
        run3(2'b10, 0, 1);
`endif
        for (int i = 0; i < 4; i++)
            run3(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 0);

        run8(2'b10);
        run8(2'($urandom_range(0, 3)));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
